// File: rtl/pc_unit.sv
// Program counter at the head of IF: sequential step, stall hold, branch/jump redirect, exception entry, ERET.
// Latency: pc is registered and updates one edge after its request; a redirect taken under stall applies on the first unstalled edge.
// Backpressure: stall holds pc and parks the newest redirect; exc_req/eret_req override stall and drop any parked redirect.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
  parameter int               STEP      = 4,
  parameter logic [WIDTH-1:0] IMEM_BASE = 32'h0000_3000,
  parameter logic [WIDTH:0]   IMEM_SIZE = 33'h0_0000_4000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             redir_pending,
  output logic             fetch_exc
);

  typedef enum logic {SEQ = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  // One extra bit so an IMEM ending exactly at the top of the address space does not wrap to zero.
  localparam logic [WIDTH:0]   IMEM_END = {1'b0, IMEM_BASE} + IMEM_SIZE;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] pc_q, pc_nxt;
  logic [WIDTH-1:0] pend_q, pend_nxt;
  logic [WIDTH:0]   base_off;

  // Register the PC, the redirect-buffer state and the buffered target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEQ;
      pc_q    <= RESET_VEC;
      pend_q  <= '0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      pend_q  <= pend_nxt;
    end
  end

  // Priority-ordered next-PC selection: exception, ERET, stalled redirect, stall, live redirect, buffered redirect, step.
  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    pend_nxt  = pend_q;
    if (exc_req) begin
      pc_nxt    = EXC_VEC;
      state_nxt = SEQ;
    end else if (eret_req) begin
      pc_nxt    = epc;
      state_nxt = SEQ;
    end else if (stall && br_valid) begin
      // Latest redirect wins; an older parked target is simply overwritten.
      pend_nxt  = br_target;
      state_nxt = HOLD;
    end else if (stall) begin
      pc_nxt    = pc_q;
    end else if (br_valid) begin
      // A live redirect is younger than anything parked, so it supersedes it.
      pc_nxt    = br_target;
      state_nxt = SEQ;
    end else if (state_q == HOLD) begin
      pc_nxt    = pend_q;
      state_nxt = SEQ;
    end else begin
      pc_nxt    = pc_q + STEP_W;
    end
  end

  // Below-base test via borrow of pc - IMEM_BASE, which stays meaningful when IMEM_BASE is zero.
  always_comb begin
    base_off  = {1'b0, pc_q} - {1'b0, IMEM_BASE};
    fetch_exc = (pc_q[1:0] != 2'b00) | base_off[WIDTH] | ({1'b0, pc_q} >= IMEM_END);
  end

  assign pc            = pc_q;
  assign pc_plus_step  = pc_q + STEP_W;
  assign redir_pending = (state_q == HOLD);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a vector table for steady-state behaviour plus hand sequences for reset and wrap.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall, br_valid, exc_req, eret_req;
  logic [31:0] br_target, epc;
  logic [31:0] pc, pc_plus_step;
  logic        redir_pending, fetch_exc;

  logic [7:0]  pc8, plus8;
  logic        pend8, fexc8;
  logic        zero1;
  logic [7:0]  zero8;

  int checks;
  int failures;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_target(br_target),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc), .pc(pc), .pc_plus_step(pc_plus_step),
    .redir_pending(redir_pending), .fetch_exc(fetch_exc)
  );

  pc_unit #(
    .WIDTH(8), .RESET_VEC(8'hFC), .EXC_VEC(8'h80), .STEP(4),
    .IMEM_BASE(8'h00), .IMEM_SIZE(9'h100)
  ) dut8 (
    .clk(clk), .reset(reset), .stall(zero1), .br_valid(zero1), .br_target(zero8),
    .exc_req(zero1), .eret_req(zero1), .epc(zero8), .pc(pc8), .pc_plus_step(plus8),
    .redir_pending(pend8), .fetch_exc(fexc8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] exp_pc;
    logic        exp_pend;
    logic        exp_fexc;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  function automatic vec_t mk(logic s, logic b, logic [31:0] bt, logic x, logic e, logic [31:0] ep,
                              logic [31:0] xpc, logic xpend, logic xfexc);
    vec_t v;
    v.stall = s; v.br_valid = b; v.br_target = bt; v.exc_req = x; v.eret_req = e; v.epc = ep;
    v.exp_pc = xpc; v.exp_pend = xpend; v.exp_fexc = xfexc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; br_valid = 0; br_target = '0; exc_req = 0; eret_req = 0; epc = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    zero1 = 1'b0; zero8 = 8'h00;
    idle_inputs();

    //                 stall br  target        exc eret epc           exp_pc        pend fexc
    tbl[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 0, 0);
    tbl[1]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, 0, 0);
    tbl[2]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_300C, 0, 0);
    tbl[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3010, 0, 0);
    tbl[4]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3010, 0, 0);
    tbl[5]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3010, 0, 0);
    tbl[6]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3014, 0, 0);
    tbl[7]  = mk(0, 1, 32'h3010,     0, 0, 32'h0,        32'h0000_3010, 0, 0);
    tbl[8]  = mk(1, 1, 32'h3040,     0, 0, 32'h0,        32'h0000_3010, 1, 0);
    tbl[9]  = mk(1, 1, 32'h3080,     0, 0, 32'h0,        32'h0000_3010, 1, 0);
    tbl[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3080, 0, 0);
    tbl[11] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3084, 0, 0);
    tbl[12] = mk(1, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_3084, 1, 0);
    tbl[13] = mk(1, 0, 32'h0,        1, 0, 32'h0,        32'h0000_4180, 0, 0);
    tbl[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_4184, 0, 0);
    tbl[15] = mk(0, 0, 32'h0,        1, 1, 32'h3022,     32'h0000_4180, 0, 0);
    tbl[16] = mk(0, 0, 32'h0,        0, 1, 32'h3022,     32'h0000_3022, 0, 1);
    tbl[17] = mk(0, 1, 32'h7000,     0, 0, 32'h0,        32'h0000_7000, 0, 1);
    tbl[18] = mk(0, 1, 32'h6FFC,     0, 0, 32'h0,        32'h0000_6FFC, 0, 0);
    tbl[19] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_7000, 0, 1);
    tbl[20] = mk(1, 1, 32'h3200,     0, 0, 32'h0,        32'h0000_7000, 1, 1);
    tbl[21] = mk(0, 1, 32'h3300,     0, 0, 32'h0,        32'h0000_3300, 0, 0);
    tbl[22] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3304, 0, 0);
    tbl[23] = mk(1, 1, 32'h3400,     0, 0, 32'h0,        32'h0000_3304, 1, 0);
    tbl[24] = mk(1, 0, 32'h0,        0, 1, 32'h3500,     32'h0000_3500, 0, 0);
    tbl[25] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3504, 0, 0);
    tbl[26] = mk(1, 1, 32'h2FFC,     0, 0, 32'h0,        32'h0000_3504, 1, 0);
    tbl[27] = mk(1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3504, 1, 0);
    tbl[28] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_2FFC, 0, 1);
    tbl[29] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 0, 0);

    // Reset state, then three free-running edges, then an async reset between edges.
    reset = 1'b1;
    repeat (2) tick();
    check("reset_pc",   pc,            32'h0000_3000);
    check("reset_pend", {31'b0, redir_pending}, 32'h0);
    check("reset_fexc", {31'b0, fetch_exc},     32'h0);
    check("reset_plus", pc_plus_step,  32'h0000_3004);
    reset = 1'b0;
    tick(); check("run1_pc", pc, 32'h0000_3004);
    tick(); check("run2_pc", pc, 32'h0000_3008);
    tick(); check("run3_pc", pc, 32'h0000_300C);
    #3 reset = 1'b1;
    #1 check("async_reset_pc", pc, 32'h0000_3000);
    #1 reset = 1'b0;

    // Vector table, starting from pc = 0x3000.
    for (int i = 0; i < NV; i++) begin
      stall = tbl[i].stall; br_valid = tbl[i].br_valid; br_target = tbl[i].br_target;
      exc_req = tbl[i].exc_req; eret_req = tbl[i].eret_req; epc = tbl[i].epc;
      tick();
      check($sformatf("vec%0d_pc", i),   pc,                      tbl[i].exp_pc);
      check($sformatf("vec%0d_pend", i), {31'b0, redir_pending},  {31'b0, tbl[i].exp_pend});
      check($sformatf("vec%0d_fexc", i), {31'b0, fetch_exc},      {31'b0, tbl[i].exp_fexc});
      check($sformatf("vec%0d_plus", i), pc_plus_step,            tbl[i].exp_pc + 32'd4);
    end

    // Async reset while a redirect is parked: buffer and target must both clear.
    idle_inputs();
    stall = 1; br_valid = 1; br_target = 32'h0000_3600;
    tick();
    check("park_pend", {31'b0, redir_pending}, 32'h1);
    #2 reset = 1'b1;
    #1 check("park_reset_pc",   pc,                     32'h0000_3000);
    check("park_reset_pend", {31'b0, redir_pending}, 32'h0);
    idle_inputs();
    #1 reset = 1'b0;
    tick();
    check("post_reset_pc", pc, 32'h0000_3004);

    // 8-bit instance: wraps from 0xFC to 0x00 silently, whole space is legal IMEM.
    #2 reset = 1'b1;
    #1 check("w8_reset_pc", {24'b0, pc8},   32'h0000_00FC);
    check("w8_reset_plus", {24'b0, plus8},  32'h0);
    check("w8_reset_fexc", {31'b0, fexc8},  32'h0);
    #1 reset = 1'b0;
    tick();
    check("w8_wrap_pc",   {24'b0, pc8},   32'h0);
    check("w8_wrap_fexc", {31'b0, fexc8}, 32'h0);
    check("w8_wrap_pend", {31'b0, pend8}, 32'h0);
    tick();
    check("w8_next_pc",   {24'b0, pc8},   32'h0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
